irrigation_scheduler: RTL
=========================

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter N_AREAS, default 4, number of irrigated areas (2..16).
REQ-002 Parameter DEBOUNCE, default 3, consecutive cycles a sensor must hold a new level before it is accepted (1..15).
REQ-003 Parameter WATER_TIME, default 8, maximum cycles a valve stays open per watering turn (>=1).
REQ-004 Parameter SETTLE_TIME, default 2, cycles all valves stay closed after a watering turn (>=1).
REQ-005 clock  input  1  single system clock, all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 U  input  N_AREAS  raw low-humidity sensor flags, bit i = 1 means area i is dry; asynchronous to nothing, sampled on clock.
REQ-008 enable  input  1  irrigation permitted; 0 forbids opening any valve.
REQ-009 Saida  output  N_AREAS  debounced low-humidity flags, same encoding as U (all zero = every area adequate).
REQ-010 valve  output  N_AREAS  one-hot-or-zero valve drive; bit i = 1 opens area i.
REQ-011 busy  output  1  high while in WATER or SETTLE.
REQ-012 area_idx  output  max(1,$clog2(N_AREAS))  index of the area being watered; holds last watered index otherwise.

Function
REQ-013 Each Saida[i] SHALL change to U[i] at the rising edge on which U[i] has differed from Saida[i] for DEBOUNCE consecutive sampled edges; any intermediate match restarts the count.
REQ-014 Debounce counters SHALL be $clog2(DEBOUNCE+1) bits and SHALL saturate, never wrap.
REQ-015 The FSM SHALL have exactly three states: IDLE, WATER, SETTLE.
REQ-016 IDLE -> WATER when enable=1 and Saida != 0; the selected area SHALL be the first set Saida bit searching upward from (last area_idx + 1) modulo N_AREAS (round-robin); area_idx and valve update on that same edge.
REQ-017 In WATER exactly one valve bit SHALL be high, matching area_idx; a turn counter counts elapsed WATER cycles.
REQ-018 WATER -> SETTLE when the counter reaches WATER_TIME, or when Saida[area_idx] falls to 0 (area wet early), whichever first; valve goes to 0 on that edge.
REQ-019 WATER -> IDLE with valve 0 when enable falls to 0 (abort), taking priority over REQ-018 on the same edge; no SETTLE is performed.
REQ-020 SETTLE lasts exactly SETTLE_TIME cycles, then returns to IDLE; enable and Saida are ignored during SETTLE.
REQ-021 valve SHALL be all zero in IDLE and SETTLE; at most one bit ever high.
REQ-022 Saida SHALL continue debouncing in every state, independent of the FSM.
REQ-023 When only one area is dry, round-robin SHALL reselect that same area after SETTLE.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, Saida 0, valve 0, busy 0, area_idx N_AREAS-1 (so first search starts at area 0), all counters 0.
REQ-025 Reset asserted mid-WATER SHALL close the valve asynchronously, without waiting for a clock edge.

Structure
REQ-026 Package irrigation_pkg SHALL hold the state enum (IDLE, WATER, SETTLE) and default parameter constants.
REQ-027 Per-bit debouncing SHALL be a sub-module moisture_debounce (parameter DEBOUNCE; ports clock, reset, din, dout), instantiated N_AREAS times.

Verification (defaults N_AREAS=4, DEBOUNCE=3, WATER_TIME=8, SETTLE_TIME=2)
REQ-028 U=0001 held, enable=1 -> Saida=0001 at third edge, valve=0001 next edge for 8 cycles, then 0000 for 2 cycles, then 0001 reopens.
REQ-029 U[0] glitches high for 2 cycles then low -> Saida stays 0000, valve stays 0000.
REQ-030 U=1011 steady, enable=1 -> watering order area 0, 1, 3, 0 (round-robin), each turn separated by 2 closed cycles.
REQ-031 Watering area 2, U[2] drops to 0 at WATER cycle 3 -> Saida[2] falls 3 edges later, valve closes same edge, SETTLE follows.
REQ-032 enable deasserted during WATER -> valve 0000 and IDLE next edge, no SETTLE; reset pulse mid-WATER -> valve 0000 immediately, area_idx=3, Saida=0000.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared FSM encoding and default sizing for the irrigation scheduler.
// Constants only; no logic.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATER  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int DEF_N_AREAS     = 4;
    localparam int DEF_DEBOUNCE    = 3;
    localparam int DEF_WATER_TIME  = 8;
    localparam int DEF_SETTLE_TIME = 2;

endpackage

// File: rtl/moisture_debounce.sv
// Single-bit sensor debouncer; dout takes din after DEBOUNCE consecutive differing samples.
// Latency DEBOUNCE edges; no backpressure, samples every cycle.
module moisture_debounce
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;

    // cnt holds how many earlier edges in a row saw din != dout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt >= LAST) begin
            dout <= din;
            cnt  <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// Round-robin irrigation valve scheduler over debounced dryness flags.
// Valve opens one edge after a dry flag is seen; no backpressure, enable gates new turns.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int N_AREAS     = DEF_N_AREAS,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int WATER_TIME  = DEF_WATER_TIME,
    parameter int SETTLE_TIME = DEF_SETTLE_TIME,
    localparam int AW         = (N_AREAS > 2) ? $clog2(N_AREAS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_AREAS-1:0] U,
    input  logic               enable,
    output logic [N_AREAS-1:0] Saida,
    output logic [N_AREAS-1:0] valve,
    output logic               busy,
    output logic [AW-1:0]      area_idx
);

    localparam int WW = $clog2(WATER_TIME + 1);
    localparam int SW = $clog2(SETTLE_TIME + 1);
    localparam logic [WW-1:0] W_LAST = WW'(WATER_TIME - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_TIME - 1);

    state_t               state, state_n;
    logic [AW-1:0]        area_n;
    logic [N_AREAS-1:0]   valve_r, valve_n;
    logic [WW-1:0]        wcnt, wcnt_n;
    logic [SW-1:0]        scnt, scnt_n;
    logic                 dispatch;
    logic                 pick_found;
    logic [AW-1:0]        pick_idx;
    logic [N_AREAS-1:0]   pick_1h;

    for (genvar g = 0; g < N_AREAS; g++) begin : g_deb
        moisture_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clock (clock),
            .reset (reset),
            .din   (U[g]),
            .dout  (Saida[g])
        );
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = area_idx;
        for (int i = 1; i <= N_AREAS; i++) begin
            if (!pick_found && Saida[(int'(area_idx) + i) % N_AREAS]) begin
                pick_found = 1'b1;
                pick_idx   = AW'((int'(area_idx) + i) % N_AREAS);
            end
        end
    end

    assign pick_1h = N_AREAS'(1) << pick_idx;

    always_comb begin
        state_n  = state;
        area_n   = area_idx;
        valve_n  = valve_r;
        wcnt_n   = wcnt;
        scnt_n   = scnt;
        dispatch = 1'b0;
        case (state)
            IDLE: dispatch = 1'b1;
            WATER: begin
                wcnt_n = wcnt + 1'b1;
                if (!enable) begin
                    state_n = IDLE;
                    valve_n = '0;
                end else if (!Saida[area_idx]) begin
                    // The output gate already closed the valve one cycle ago; that cycle counts as settle.
                    valve_n = '0;
                    if (SETTLE_TIME == 1) begin
                        dispatch = 1'b1;
                    end else begin
                        state_n = SETTLE;
                        scnt_n  = SW'(1);
                    end
                end else if (wcnt == W_LAST) begin
                    state_n = SETTLE;
                    valve_n = '0;
                    scnt_n  = '0;
                end
            end
            SETTLE: begin
                scnt_n = scnt + 1'b1;
                if (scnt >= S_LAST) dispatch = 1'b1;
            end
            default: begin
                state_n = IDLE;
                valve_n = '0;
            end
        endcase
        // Settle hands straight to the idle decision so the closed gap is exactly SETTLE_TIME.
        if (dispatch) begin
            if (enable && pick_found) begin
                state_n = WATER;
                area_n  = pick_idx;
                valve_n = pick_1h;
                wcnt_n  = '0;
            end else begin
                state_n = IDLE;
                valve_n = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            area_idx <= AW'(N_AREAS - 1);
            valve_r  <= '0;
            wcnt     <= '0;
            scnt     <= '0;
        end else begin
            state    <= state_n;
            area_idx <= area_n;
            valve_r  <= valve_n;
            wcnt     <= wcnt_n;
            scnt     <= scnt_n;
        end
    end

    // Gating by Saida closes the valve on the very edge the area's flag clears.
    assign valve = valve_r & Saida;
    assign busy  = (state != IDLE);

endmodule
